mdu_hilo: RTL and testbench

- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits in EXE beside the combinational ALU. The pipeline launches an operation with a one-cycle start pulse, stalls on busy, and reads hi/lo for MFHI/MFLO.
- Iterative datapath: one partial product or one quotient bit per cycle.

---
 rtl/mdu_hilo.sv | 223 ++++++++++++++++++++++
 tb/tb_mdu_hilo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit with architectural HI/LO registers.
// One multiplier bit (shift-add) or one quotient bit (restoring divide) is
// processed per clock. Signed operations run on magnitudes and the result
// signs are fixed up on the final iteration. HI/LO are only ever written by a
// completed MULT/DIV, by MTHI/MTLO, or by reset.
module mdu_hilo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       oper,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  state_t                 state_r, state_s;
  logic                   busy_r, done_r;
  logic [WIDTH-1:0]       hi_r, lo_r;
  logic [WIDTH-1:0]       acc_r;     // product high half / partial remainder
  logic [WIDTH-1:0]       q_r;       // multiplier bits / dividend-quotient shifter
  logic [WIDTH-1:0]       opb_r;     // multiplicand / divisor magnitude
  logic [CNT_W-1:0]       cnt_r;
  logic                   neg_lo_r;  // negate product, or negate quotient
  logic                   neg_hi_r;  // negate remainder
  logic                   div0_r;    // divisor was zero

  logic                   go_s, is_mul_s, is_div_s, is_signed_s;
  logic                   sa_s, sb_s, b_zero_s, last_s;
  logic [WIDTH-1:0]       mag_a_s, mag_b_s;
  logic [WIDTH:0]         mul_sum_s, div_trial_s;
  logic                   div_ok_s;
  logic [WIDTH-1:0]       mul_acc_s, mul_q_s, div_acc_s, div_q_s;
  logic [2*WIDTH-1:0]     prod_s, prod_fin_s;
  logic [WIDTH-1:0]       quo_fin_s, rem_fin_s;

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

  // Launch decode: operand magnitudes and result signs for a new operation.
  always_comb begin
    go_s        = (state_r == ST_IDLE) && start && !cancel;
    is_mul_s    = (oper == OP_MULT) || (oper == OP_MULTU);
    is_div_s    = (oper == OP_DIV)  || (oper == OP_DIVU);
    is_signed_s = (oper == OP_MULT) || (oper == OP_DIV);
    sa_s        = is_signed_s & a[WIDTH-1];
    sb_s        = is_signed_s & b[WIDTH-1];
    b_zero_s    = (b == ZERO_W);
    mag_a_s     = sa_s ? (ZERO_W - a) : a;
    mag_b_s     = sb_s ? (ZERO_W - b) : b;
    last_s      = (cnt_r == LAST_CNT);
  end

  // Next-state logic: launch from IDLE, return on final iteration or cancel.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (go_s && is_mul_s) begin
          state_s = ST_MUL;
        end else if (go_s && is_div_s) begin
          state_s = ST_DIV;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (cancel || last_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // One iteration step for both datapaths plus the sign-corrected final results.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r} + (q_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
    mul_acc_s   = mul_sum_s[WIDTH:1];
    mul_q_s     = {mul_sum_s[0], q_r[WIDTH-1:1]};
    div_trial_s = {acc_r, q_r[WIDTH-1]} - {1'b0, opb_r};
    div_ok_s    = !div_trial_s[WIDTH];
    if (div_ok_s) begin
      div_acc_s = div_trial_s[WIDTH-1:0];
    end else begin
      div_acc_s = {acc_r[WIDTH-2:0], q_r[WIDTH-1]};
    end
    div_q_s     = {q_r[WIDTH-2:0], div_ok_s};
    prod_s      = {mul_acc_s, mul_q_s};
    if (neg_lo_r) begin
      prod_fin_s = {(2*WIDTH){1'b0}} - prod_s;
    end else begin
      prod_fin_s = prod_s;
    end
    if (div0_r) begin
      quo_fin_s = ONES_W;
    end else if (neg_lo_r) begin
      quo_fin_s = ZERO_W - div_q_s;
    end else begin
      quo_fin_s = div_q_s;
    end
    if (neg_hi_r) begin
      rem_fin_s = ZERO_W - div_acc_s;
    end else begin
      rem_fin_s = div_acc_s;
    end
  end

  // State register and busy flag (busy mirrors "not IDLE" after each edge).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
    end
  end

  // Datapath: operand latch, per-cycle iteration, HI/LO writes and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r     <= ZERO_W;
      lo_r     <= ZERO_W;
      done_r   <= 1'b0;
      acc_r    <= ZERO_W;
      q_r      <= ZERO_W;
      opb_r    <= ZERO_W;
      cnt_r    <= {CNT_W{1'b0}};
      neg_lo_r <= 1'b0;
      neg_hi_r <= 1'b0;
      div0_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (go_s) begin
            case (oper)
              OP_MULT, OP_MULTU: begin
                acc_r    <= ZERO_W;
                q_r      <= mag_b_s;
                opb_r    <= mag_a_s;
                cnt_r    <= {CNT_W{1'b0}};
                neg_lo_r <= sa_s ^ sb_s;
                neg_hi_r <= sa_s ^ sb_s;
                div0_r   <= 1'b0;
              end
              OP_DIV, OP_DIVU: begin
                acc_r    <= ZERO_W;
                q_r      <= mag_a_s;
                opb_r    <= mag_b_s;
                cnt_r    <= {CNT_W{1'b0}};
                neg_lo_r <= (sa_s ^ sb_s) & !b_zero_s;
                neg_hi_r <= sa_s;
                div0_r   <= b_zero_s;
              end
              OP_MTHI: hi_r <= a;
              OP_MTLO: lo_r <= a;
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (cancel) begin
            cnt_r <= {CNT_W{1'b0}};
          end else if (last_s) begin
            hi_r   <= prod_fin_s[2*WIDTH-1:WIDTH];
            lo_r   <= prod_fin_s[WIDTH-1:0];
            done_r <= 1'b1;
            cnt_r  <= {CNT_W{1'b0}};
          end else begin
            acc_r <= mul_acc_s;
            q_r   <= mul_q_s;
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DIV: begin
          if (cancel) begin
            cnt_r <= {CNT_W{1'b0}};
          end else if (last_s) begin
            hi_r   <= rem_fin_s;
            lo_r   <= quo_fin_s;
            done_r <= 1'b1;
            cnt_r  <= {CNT_W{1'b0}};
          end else begin
            acc_r <= div_acc_s;
            q_r   <= div_q_s;
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: cnt_r <= {CNT_W{1'b0}};
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: expected {hi,lo} pushed on issue, a negedge
// monitor pops and compares whenever done pulses.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [2:0]  oper = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_hilo #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .oper(oper), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: {hi,lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p, q, r;
    logic [63:0] res;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    res = 64'd0;
    case (op)
      3'd1: begin p = sx * sy; res = p; end
      3'd2: res = {32'd0, x} * {32'd0, y};
      3'd3: begin
        if (y == 32'd0) res = {x, 32'hFFFFFFFF};
        else begin q = sx / sy; r = sx % sy; res = {r[31:0], q[31:0]}; end
      end
      3'd4: begin
        if (y == 32'd0) res = {x, 32'hFFFFFFFF};
        else res = {x % y, x / y};
      end
      default: res = {m_hi, m_lo};
    endcase
    return res;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      check("done_with_busy", {63'd0, busy}, 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
      end else begin
        check("result_hilo", {hi, lo}, exp_q.pop_front());
      end
    end
  end

  // Issue one MULT/DIV op; optionally cancel, reset, or poke start mid-flight.
  task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input int cancel_at, input int rst_at, input int start_at);
    logic [63:0] r;
    int n, exp_n;
    bit stable;
    r = model(op, av, bv);
    if (cancel_at < 0 && rst_at < 0) exp_q.push_back(r);
    @(negedge clk);
    start = 1'b1; oper = op; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; oper = 3'($urandom); a = $urandom; b = $urandom;
    n = 0; stable = 1'b1;
    while (busy === 1'b1 && n < 100) begin
      if (hi !== m_hi || lo !== m_lo) stable = 1'b0;
      n++;
      if (n == cancel_at) cancel = 1'b1;
      if (n == rst_at) rst = 1'b1;
      if (n == start_at) begin start = 1'b1; oper = 3'd1; end
      @(negedge clk);
      cancel = 1'b0; rst = 1'b0; start = 1'b0;
    end
    exp_n = (cancel_at > 0) ? cancel_at : ((rst_at > 0) ? rst_at : 32);
    check("busy_cycles", 64'(n), 64'(exp_n));
    check("hilo_stable_in_busy", {63'd0, stable}, 64'd1);
    if (rst_at > 0) begin
      m_hi = 32'd0; m_lo = 32'd0;
      check("rst_clears_hilo", {hi, lo}, 64'd0);
      check("rst_no_done", {63'd0, done}, 64'd0);
    end else if (cancel_at > 0) begin
      check("cancel_keeps_hilo", {hi, lo}, {m_hi, m_lo});
      check("cancel_no_done", {63'd0, done}, 64'd0);
    end else begin
      m_hi = r[63:32]; m_lo = r[31:0];
      check("done_pulse", {63'd0, done}, 64'd1);
    end
    @(negedge clk);
    check("idle_after_op", {62'd0, busy, done}, 64'd0);
  endtask

  // Start with a non-launching oper (NOP/MTHI/MTLO/reserved) from IDLE.
  task automatic simple_op(input logic [2:0] op, input logic [31:0] av, input logic with_cancel);
    @(negedge clk);
    start = 1'b1; oper = op; a = av; cancel = with_cancel;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    if (!with_cancel && op == 3'd5) m_hi = av;
    if (!with_cancel && op == 3'd6) m_lo = av;
    check("simple_hilo", {hi, lo}, {m_hi, m_lo});
    check("simple_idle", {62'd0, busy, done}, 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    check("reset_state", {hi, lo}, 64'd0);
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);
    rst = 1'b0;

    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1, -1);
    check("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
    run_op(3'd1, 32'hFFFFFFFD, 32'd7, -1, -1, -1);
    check("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    run_op(3'd2, 32'hFFFFFFFD, 32'd7, -1, -1, -1);
    check("multu_same", {hi, lo}, 64'h00000006_FFFFFFEB);
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, -1, -1, -1);
    check("div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(3'd4, 32'd100, 32'd7, -1, -1, -1);
    check("divu_100_7", {hi, lo}, {32'd2, 32'd14});
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, -1, -1, -1);
    check("div_overflow", {hi, lo}, 64'h00000000_80000000);
    run_op(3'd4, 32'h1234, 32'd0, -1, -1, 5);
    check("divu_by_zero", {hi, lo}, 64'h00001234_FFFFFFFF);
    run_op(3'd3, 32'hFFFFFF00, 32'd0, -1, -1, -1);
    check("div_by_zero_neg", {hi, lo}, 64'hFFFFFF00_FFFFFFFF);

    // MTHI then MTLO on consecutive edges
    @(negedge clk);
    start = 1'b1; oper = 3'd5; a = 32'hAAAA5555;
    @(negedge clk);
    oper = 3'd6; a = 32'h0F0F0F0F;
    check("mthi_edge", {hi, lo}, {32'hAAAA5555, m_lo});
    check("mthi_idle", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    m_hi = 32'hAAAA5555; m_lo = 32'h0F0F0F0F;
    check("mtlo_edge", {hi, lo}, 64'hAAAA5555_0F0F0F0F);
    check("mtlo_idle", {62'd0, busy, done}, 64'd0);

    run_op(3'd4, 32'd1000, 32'd3, 10, -1, -1);
    check("cancel_hilo", {hi, lo}, 64'hAAAA5555_0F0F0F0F);
    run_op(3'd1, 32'h12345678, 32'h9ABCDEF0, 32, -1, -1);
    check("cancel_last_wins", {hi, lo}, 64'hAAAA5555_0F0F0F0F);

    run_op(3'd2, 32'hDEADBEEF, 32'hCAFEF00D, -1, 20, -1);
    run_op(3'd2, 32'd3, 32'd5, -1, -1, -1);
    check("multu_3x5", {hi, lo}, 64'd15);

    simple_op(3'd0, 32'h11111111, 1'b0);
    simple_op(3'd7, 32'h22222222, 1'b0);
    simple_op(3'd5, 32'h33333333, 1'b1);
    simple_op(3'd2, 32'h44444444, 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      int c;
      op = 3'($urandom_range(1, 6));
      if (op >= 3'd5) begin
        simple_op(op, $urandom, 1'b0);
      end else begin
        c = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 32)) : -1;
        run_op(op, pick(), pick(), c, -1, -1);
      end
    end

    repeat (2) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
